video_capture: RTL and testbench
================================

Name: video_capture

Overview:
- Receiver counterpart of the VGA scan-out path: samples an incoming parallel video stream (HS, VS, BLANK, RGB) in the pixel_clk domain.
- Writes each active pixel into the SDRAM framebuffer through Wishbone single-write cycles.
- An async FIFO carries pixels from pixel_clk to wshb_clk. Framebuffer layout is the one scan-out reads: one 32-bit word per pixel, row-major, 4*(HDISP*y+x).

Parameters:
- HDISP, 800, active pixels per line
- VDISP, 480, active lines per frame
- BASE_ADDR, 32'h0, byte address of framebuffer pixel (0,0)
- FIFO_DEPTH_WIDTH, 8, log2 of FIFO depth (256 words)

Ports:
- pixel_clk  in  1  pixel clock
- pixel_rst  in  1  async active-high reset, pixel domain
- wshb_clk  in  1  Wishbone clock
- wshb_rst  in  1  async active-high reset, Wishbone domain
- vid_hs  in  1  horizontal sync, active low
- vid_vs  in  1  vertical sync, active low
- vid_blank  in  1  high = active pixel
- vid_rgb  in  24  pixel data
- capture_en  in  1  pixel domain; capture enable, honoured at frame boundaries only
- frame_count  out  16  pixel domain; complete frames captured, wraps
- overflow  out  1  pixel domain; sticky, FIFO full on push
- err_geom  out  1  pixel domain; sticky, frame pixel count differed from HDISP*VDISP
- wshb_adr  out  32  byte address
- wshb_dat_ms  out  32  {8'h00, rgb}
- wshb_we  out  1  constant 1
- wshb_sel  out  4  constant 4'hF
- wshb_cti  out  3  constant 0
- wshb_bte  out  2  constant 0
- wshb_cyc  out  1  cycle request
- wshb_stb  out  1  equals wshb_cyc
- wshb_ack  in  1  slave acknowledge

Behaviour:

Reset and input stage
- Reset pixel_rst (async, active-high), clock pixel_clk.
- On reset: frame_count=0, overflow=0, err_geom=0, state IDLE.
- Video inputs are registered once. A pixel present at the inputs is pushed 2 pixel_clk edges later.

Pixel-domain FSM (IDLE, WAIT_VS, ACTIVE)
- VS fall = registered vs 1 then 0.
- IDLE -> WAIT_VS when capture_en=1.
- WAIT_VS -> ACTIVE on VS fall; clear pix_cnt and set sof_pending.
- ACTIVE, blank=1 and pix_cnt < HDISP*VDISP: push {7'b0, sof_pending, rgb}, clear sof_pending, pix_cnt++.
- ACTIVE, blank=1 and pix_cnt = HDISP*VDISP: pixel dropped, err_geom=1.
- ACTIVE, on next VS fall:
  - pix_cnt == HDISP*VDISP: frame_count++.
  - otherwise: err_geom=1 and frame_count unchanged.
  - Then: capture_en=1 -> restart ACTIVE (same as the WAIT_VS entry); capture_en=0 -> IDLE.
- Push while wfull: pixel dropped, overflow=1, go to WAIT_VS (frame abandoned, frame_count unchanged).
- capture_en falling mid-frame has no effect until the next VS fall.

FIFO
- Word layout [23:0] rgb, [24] SOF.
- First-word-fall-through: rdata holds the head word while rempty=0.
- FIFO rst = pixel_rst | wshb_rst.

Wishbone domain
- Reset wshb_rst (async): idx=0, cyc=0.
- cyc=stb=!rempty, combinational from FIFO state.
- wshb_adr = BASE_ADDR + 4*(head.SOF ? 0 : idx).
- On ack: pop, then idx = (head.SOF ? 0 : idx) + 1; wraps to 0 after HDISP*VDISP-1.
- cyc stays high across back-to-back acks while the FIFO is non-empty.
- Data and address are stable from cyc rise until ack.
- An SOF word always lands at BASE_ADDR, so abandoned or short frames self-realign on the next frame.
- pixel_rst mid-transfer: the FIFO is flushed. The current cycle is undefined for one wshb_clk, then cyc=0.

Widths
- pix_cnt and idx are $clog2(HDISP*VDISP+1) bits.
- Address arithmetic is done in 32 bits.

Decomposition:
- Package video_capture_pkg: state enum (IDLE, WAIT_VS, ACTIVE), FIFO word struct {sof, rgb}, SOF bit index constant.
- Sub-module: reuse the existing async_fifo (DATA_WIDTH 32, DEPTH_WIDTH FIFO_DEPTH_WIDTH).
- Add a local wshb_writer sub-module holding idx, address generation and cyc/stb.

Test Plan (HDISP=8, VDISP=4; bench generator has 2-pixel porches and rgb=24'h000000+pixel index):
1. Resets asserted, then released, with capture_en=0 -> cyc=0, frame_count=0, overflow=0, err_geom=0; no FIFO pushes over 2 frames.
2. capture_en=1, slave acks each cycle, one frame -> 32 writes at adr 0x00..0x7C step 4, dat_ms=0x00..0x1F; frame_count=1 at the following VS fall.
3. Second consecutive frame -> first write again at adr 0x00 (SOF), frame_count=2, err_geom=0.
4. Slave withholds ack with FIFO_DEPTH_WIDTH=4 -> overflow=1 after 16 buffered words, state WAIT_VS, frame_count unchanged. Release ack -> 16 buffered writes at 0x00..0x3C, then next frame starts at 0x00.
5. Generator issues VS after 20 active pixels -> err_geom=1, frame_count unchanged; next full frame writes from adr 0x00 and increments frame_count.
6. capture_en deasserted at pixel 10 of a frame -> that frame completes (32 writes, frame_count+1), then IDLE with no further pushes.

Source files
------------

// File: rtl/video_capture_pkg.sv
// video_capture_pkg: shared types for the video capture path.
//   cap_state_e  - pixel-domain capture FSM states
//   fifo_word_t  - word carried across the clock-domain FIFO
package video_capture_pkg;

    localparam int RGB_W   = 24;
    localparam int WORD_W  = 32;
    localparam int SOF_BIT = 24;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        ACTIVE  = 2'd2
    } cap_state_e;

    // Layout matches the FIFO word: [23:0] rgb, [24] start-of-frame.
    typedef struct packed {
        logic [WORD_W-RGB_W-2:0] rsvd;
        logic                    sof;
        logic [RGB_W-1:0]        rgb;
    } fifo_word_t;

endpackage

// File: rtl/async_fifo.sv
// async_fifo: dual-clock FIFO, gray-coded pointers, first-word-fall-through.
//   wclk_i/winc_i/wdata_i/wfull_o   - write side
//   rclk_i/rinc_i/rdata_o/rempty_o  - read side; rdata_o is the head word
//                                      whenever rempty_o is low
//   rst_i                           - async active-high, clears both sides
module async_fifo #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WIDTH = 8
) (
    input  logic                  wclk_i,
    input  logic                  rclk_i,
    input  logic                  rst_i,
    input  logic                  winc_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  wfull_o,
    input  logic                  rinc_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rempty_o
);
    localparam int DEPTH = 1 << DEPTH_WIDTH;
    localparam int PW    = DEPTH_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0] wbin_q, wbin_d, wgray_q, wgray_d;
    logic [PW-1:0] rbin_q, rbin_d, rgray_q, rgray_d;
    logic [PW-1:0] wq1_rgray_q, wq2_rgray_q, rq1_wgray_q, rq2_wgray_q;
    logic          wfull_q, wfull_d, rempty_q, rempty_d;
    logic          push, pop;

    assign push = winc_i & ~wfull_q;
    assign pop  = rinc_i & ~rempty_q;

    // Write side
    assign wbin_d  = wbin_q + PW'(push);
    assign wgray_d = (wbin_d >> 1) ^ wbin_d;
    // Full when the write pointer has lapped the read pointer: top two gray bits inverted.
    assign wfull_d = (wgray_d == {~wq2_rgray_q[PW-1:PW-2], wq2_rgray_q[PW-3:0]});

    always_ff @(posedge wclk_i or posedge rst_i) begin
        if (rst_i) begin
            wbin_q      <= '0;
            wgray_q     <= '0;
            wfull_q     <= 1'b0;
            wq1_rgray_q <= '0;
            wq2_rgray_q <= '0;
        end else begin
            wbin_q      <= wbin_d;
            wgray_q     <= wgray_d;
            wfull_q     <= wfull_d;
            wq1_rgray_q <= rgray_q;
            wq2_rgray_q <= wq1_rgray_q;
        end
    end

    always_ff @(posedge wclk_i) begin
        if (push) mem_q[wbin_q[DEPTH_WIDTH-1:0]] <= wdata_i;
    end

    // Read side
    assign rbin_d   = rbin_q + PW'(pop);
    assign rgray_d  = (rbin_d >> 1) ^ rbin_d;
    assign rempty_d = (rgray_d == rq2_wgray_q);

    always_ff @(posedge rclk_i or posedge rst_i) begin
        if (rst_i) begin
            rbin_q      <= '0;
            rgray_q     <= '0;
            rempty_q    <= 1'b1;
            rq1_wgray_q <= '0;
            rq2_wgray_q <= '0;
        end else begin
            rbin_q      <= rbin_d;
            rgray_q     <= rgray_d;
            rempty_q    <= rempty_d;
            rq1_wgray_q <= wgray_q;
            rq2_wgray_q <= rq1_wgray_q;
        end
    end

    assign rdata_o  = mem_q[rbin_q[DEPTH_WIDTH-1:0]];
    assign wfull_o  = wfull_q;
    assign rempty_o = rempty_q;

endmodule

// File: rtl/video_capture_wshb_writer.sv
// wshb_writer: drains the FIFO into the framebuffer with Wishbone single writes.
//   clk_i/rst_i  - Wishbone clock, async active-high reset
//   rempty_i     - FIFO empty; rdata_i is the FIFO head word
//   rinc_o       - pop the head (on acknowledged write)
//   adr_o/dat_o  - byte address / write data of the head pixel
//   cyc_o        - cycle request (stb is the same signal)
//   ack_i        - slave acknowledge
module wshb_writer
    import video_capture_pkg::*;
#(
    parameter int          HDISP     = 800,
    parameter int          VDISP     = 480,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rempty_i,
    input  fifo_word_t  rdata_i,
    output logic        rinc_o,
    output logic [31:0] adr_o,
    output logic [31:0] dat_o,
    output logic        cyc_o,
    input  logic        ack_i
);
    localparam int TOTAL = HDISP * VDISP;
    localparam int IDX_W = $clog2(TOTAL + 1);

    logic [IDX_W-1:0] idx_q, idx_d, base_idx;
    logic             unused_rsvd;

    assign unused_rsvd = ^rdata_i.rsvd;

    // An SOF word restarts at pixel 0, so a short or abandoned frame never
    // shifts the next one.
    assign base_idx = rdata_i.sof ? '0 : idx_q;

    assign cyc_o  = ~rempty_i;
    assign rinc_o = cyc_o & ack_i;
    assign adr_o  = BASE_ADDR + (32'(base_idx) << 2);
    assign dat_o  = {8'h00, rdata_i.rgb};

    always_comb begin
        idx_d = idx_q;
        if (rinc_o) idx_d = (base_idx == IDX_W'(TOTAL - 1)) ? '0 : base_idx + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) idx_q <= '0;
        else       idx_q <= idx_d;
    end

endmodule

// File: rtl/video_capture.sv
// video_capture: samples a parallel video stream and writes each active pixel
// to an SDRAM framebuffer (one word per pixel, row-major) over Wishbone.
//   pixel_clk/pixel_rst        - pixel domain clock, async active-high reset
//   wshb_clk/wshb_rst          - Wishbone domain clock, async active-high reset
//   vid_hs/vid_vs/vid_blank/vid_rgb - incoming video (syncs active low,
//                                blank high = active pixel)
//   capture_en                 - capture enable, acted on at frame boundaries
//   frame_count/overflow/err_geom - pixel-domain status
//   wshb_*                     - Wishbone master, single write cycles
module video_capture
    import video_capture_pkg::*;
#(
    parameter int          HDISP            = 800,
    parameter int          VDISP            = 480,
    parameter logic [31:0] BASE_ADDR        = 32'h0,
    parameter int          FIFO_DEPTH_WIDTH = 8
) (
    input  logic        pixel_clk,
    input  logic        pixel_rst,
    input  logic        wshb_clk,
    input  logic        wshb_rst,
    input  logic        vid_hs,
    input  logic        vid_vs,
    input  logic        vid_blank,
    input  logic [23:0] vid_rgb,
    input  logic        capture_en,
    output logic [15:0] frame_count,
    output logic        overflow,
    output logic        err_geom,
    output logic [31:0] wshb_adr,
    output logic [31:0] wshb_dat_ms,
    output logic        wshb_we,
    output logic [3:0]  wshb_sel,
    output logic [2:0]  wshb_cti,
    output logic [1:0]  wshb_bte,
    output logic        wshb_cyc,
    output logic        wshb_stb,
    input  logic        wshb_ack
);
    localparam int TOTAL = HDISP * VDISP;
    localparam int PIX_W = $clog2(TOTAL + 1);

    // Line timing is fully described by blank, so hsync is not used.
    logic unused_hs;
    assign unused_hs = vid_hs;

    // Input register stage
    logic              vs_q, vs_prev_q, blank_q;
    logic [RGB_W-1:0]  rgb_q;
    logic              vs_fall;

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            vs_q      <= 1'b1;
            vs_prev_q <= 1'b1;
            blank_q   <= 1'b0;
            rgb_q     <= '0;
        end else begin
            vs_q      <= vid_vs;
            vs_prev_q <= vs_q;
            blank_q   <= vid_blank;
            rgb_q     <= vid_rgb;
        end
    end

    assign vs_fall = vs_prev_q & ~vs_q;

    // Capture FSM
    cap_state_e       state_q, state_d;
    logic [PIX_W-1:0] pix_cnt_q, pix_cnt_d;
    logic             sof_q, sof_d;
    logic [15:0]      fcnt_q, fcnt_d;
    logic             ovf_q, ovf_d, geom_q, geom_d;
    logic             wfull, push;
    fifo_word_t       wword;

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            state_q   <= IDLE;
            pix_cnt_q <= '0;
            sof_q     <= 1'b0;
            fcnt_q    <= '0;
            ovf_q     <= 1'b0;
            geom_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pix_cnt_q <= pix_cnt_d;
            sof_q     <= sof_d;
            fcnt_q    <= fcnt_d;
            ovf_q     <= ovf_d;
            geom_q    <= geom_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pix_cnt_d = pix_cnt_q;
        sof_d     = sof_q;
        fcnt_d    = fcnt_q;
        ovf_d     = ovf_q;
        geom_d    = geom_q;
        push      = 1'b0;
        wword     = '{rsvd: '0, sof: sof_q, rgb: rgb_q};
        case (state_q)
            IDLE: begin
                if (capture_en) state_d = WAIT_VS;
            end
            WAIT_VS: begin
                if (vs_fall) begin
                    state_d   = ACTIVE;
                    pix_cnt_d = '0;
                    sof_d     = 1'b1;
                end
            end
            ACTIVE: begin
                if (vs_fall) begin
                    if (pix_cnt_q == PIX_W'(TOTAL)) fcnt_d = fcnt_q + 16'd1;
                    else                            geom_d = 1'b1;
                    if (capture_en) begin
                        pix_cnt_d = '0;
                        sof_d     = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (blank_q) begin
                    if (pix_cnt_q == PIX_W'(TOTAL)) begin
                        geom_d = 1'b1;
                    end else if (wfull) begin
                        // Abandon the frame; the next SOF realigns the writer.
                        ovf_d   = 1'b1;
                        state_d = WAIT_VS;
                    end else begin
                        push      = 1'b1;
                        sof_d     = 1'b0;
                        pix_cnt_d = pix_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign frame_count = fcnt_q;
    assign overflow    = ovf_q;
    assign err_geom    = geom_q;

    // Clock crossing
    logic       fifo_rst, rempty, rinc;
    fifo_word_t rword;

    assign fifo_rst = pixel_rst | wshb_rst;

    async_fifo #(
        .DATA_WIDTH (WORD_W),
        .DEPTH_WIDTH(FIFO_DEPTH_WIDTH)
    ) u_fifo (
        .wclk_i  (pixel_clk),
        .rclk_i  (wshb_clk),
        .rst_i   (fifo_rst),
        .winc_i  (push),
        .wdata_i (wword),
        .wfull_o (wfull),
        .rinc_i  (rinc),
        .rdata_o (rword),
        .rempty_o(rempty)
    );

    wshb_writer #(
        .HDISP    (HDISP),
        .VDISP    (VDISP),
        .BASE_ADDR(BASE_ADDR)
    ) u_writer (
        .clk_i   (wshb_clk),
        .rst_i   (wshb_rst),
        .rempty_i(rempty),
        .rdata_i (rword),
        .rinc_o  (rinc),
        .adr_o   (wshb_adr),
        .dat_o   (wshb_dat_ms),
        .cyc_o   (wshb_cyc),
        .ack_i   (wshb_ack)
    );

    assign wshb_stb = wshb_cyc;
    assign wshb_we  = 1'b1;
    assign wshb_sel = 4'hF;
    assign wshb_cti = 3'd0;
    assign wshb_bte = 2'd0;

endmodule

// File: tb/tb_video_capture.sv
module tb_video_capture;
    localparam int HD   = 8;
    localparam int VD   = 4;
    localparam int TOT  = HD * VD;
    localparam logic [31:0] BASE = 32'h0;

    logic        pixel_clk = 1'b0, wshb_clk = 1'b0;
    logic        pixel_rst, wshb_rst;
    logic        vid_hs, vid_vs, vid_blank;
    logic [23:0] vid_rgb;
    logic        capture_en;
    logic [15:0] frame_count;
    logic        overflow, err_geom;
    logic [31:0] wshb_adr, wshb_dat_ms;
    logic        wshb_we;
    logic [3:0]  wshb_sel;
    logic [2:0]  wshb_cti;
    logic [1:0]  wshb_bte;
    logic        wshb_cyc, wshb_stb, wshb_ack;

    always #5 pixel_clk = ~pixel_clk;
    always #4 wshb_clk  = ~wshb_clk;

    video_capture #(
        .HDISP(HD), .VDISP(VD), .BASE_ADDR(BASE), .FIFO_DEPTH_WIDTH(4)
    ) dut (
        .pixel_clk(pixel_clk), .pixel_rst(pixel_rst),
        .wshb_clk(wshb_clk), .wshb_rst(wshb_rst),
        .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_blank(vid_blank), .vid_rgb(vid_rgb),
        .capture_en(capture_en), .frame_count(frame_count),
        .overflow(overflow), .err_geom(err_geom),
        .wshb_adr(wshb_adr), .wshb_dat_ms(wshb_dat_ms), .wshb_we(wshb_we),
        .wshb_sel(wshb_sel), .wshb_cti(wshb_cti), .wshb_bte(wshb_bte),
        .wshb_cyc(wshb_cyc), .wshb_stb(wshb_stb), .wshb_ack(wshb_ack)
    );

    int errors = 0;
    int checks = 0;
    int writes = 0;
    bit ack_hold = 1'b0;
    bit ack_rand = 1'b0;
    // Reference model: expected framebuffer writes {byte address, data} in order.
    logic [63:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wishbone slave: decides ack on the falling edge and scores each accepted write.
    initial begin
        wshb_ack = 1'b0;
        forever begin
            @(negedge wshb_clk);
            if (wshb_cyc && !ack_hold && (!ack_rand || $urandom_range(0, 2) != 0)) begin
                wshb_ack = 1'b1;
                writes++;
                checks++;
                assert (exp_q.size() > 0 && wshb_stb && wshb_we && wshb_sel == 4'hF &&
                        wshb_cti == 3'd0 && wshb_bte == 2'd0 &&
                        wshb_adr === exp_q[0][63:32] && wshb_dat_ms === exp_q[0][31:0])
                else begin
                    errors++;
                    $error("FAIL write%0d observed adr=%h dat=%h stb=%b expected %h",
                           writes, wshb_adr, wshb_dat_ms, wshb_stb,
                           (exp_q.size() > 0) ? exp_q[0] : 64'hx);
                end
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end else begin
                wshb_ack = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge pixel_clk);
    endtask

    task automatic vs_pulse();
        @(negedge pixel_clk);
        vid_vs = 1'b0; vid_blank = 1'b0;
        tick(2);
        vid_vs = 1'b1;
        tick(2);
    endtask

    // One frame: n active pixels in lines of HD, 2-pixel porches. Pixels with
    // index below cap are the ones the capture rules say reach memory.
    task automatic frame(input int n, input int cap, input bit rnd, input int drop_at);
        int k;
        logic [23:0] px;
        vs_pulse();
        k = 0;
        while (k < n) begin
            @(negedge pixel_clk); vid_hs = 1'b0; vid_blank = 1'b0;
            @(negedge pixel_clk); vid_hs = 1'b1;
            for (int x = 0; x < HD && k < n; x++) begin
                @(negedge pixel_clk);
                px = rnd ? 24'($urandom) : 24'(k);
                vid_blank = 1'b1;
                vid_rgb   = px;
                if (k == drop_at) capture_en = 1'b0;
                if (k < cap) exp_q.push_back({BASE + 32'(4 * k), 8'h00, px});
                k++;
            end
            @(negedge pixel_clk); vid_blank = 1'b0;
            tick(1);
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge wshb_clk);
        repeat (10) @(negedge wshb_clk);
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        pixel_rst = 1'b1; wshb_rst = 1'b1;
        vid_hs = 1'b1; vid_vs = 1'b1; vid_blank = 1'b0; vid_rgb = '0;
        capture_en = 1'b0;
        tick(4);
        pixel_rst = 1'b0; wshb_rst = 1'b0;
        tick(1);
        chk("rst_cyc", 32'(wshb_cyc), 32'd0);
        chk("rst_fc", 32'(frame_count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_geom", 32'(err_geom), 32'd0);

        // Capture disabled: nothing reaches the bus
        frame(TOT, 0, 1'b0, -1);
        frame(TOT, 0, 1'b0, -1);
        vs_pulse();
        drain("t1_drain");
        chk("t1_writes", 32'(writes), 32'd0);
        chk("t1_fc", 32'(frame_count), 32'd0);

        // Full frames
        capture_en = 1'b1;
        tick(3);
        frame(TOT, TOT, 1'b0, -1);
        drain("t2_drain");
        chk("t2_writes", 32'(writes), 32'd32);
        frame(TOT, TOT, 1'b0, -1);
        chk("t2_fc", 32'(frame_count), 32'd1);
        drain("t3_drain");

        // Withheld ack: FIFO (16 deep) overflows, frame abandoned
        ack_hold = 1'b1;
        frame(TOT, 16, 1'b0, -1);
        chk("t3_fc", 32'(frame_count), 32'd2);
        chk("t3_geom", 32'(err_geom), 32'd0);
        tick(10);
        chk("t4_ovf", 32'(overflow), 32'd1);
        chk("t4_cyc_held", 32'(wshb_cyc), 32'd1);
        chk("t4_writes_held", 32'(writes), 32'd64);
        ack_hold = 1'b0;
        drain("t4_drain");
        chk("t4_writes", 32'(writes), 32'd80);
        frame(TOT, TOT, 1'b0, -1);
        chk("t4_fc_keep", 32'(frame_count), 32'd2);
        drain("t4_next_drain");

        // Short frame
        frame(20, 20, 1'b0, -1);
        chk("t5_fc_prev", 32'(frame_count), 32'd3);
        chk("t5_geom_clear", 32'(err_geom), 32'd0);
        drain("t5_short_drain");
        frame(TOT, TOT, 1'b0, -1);
        chk("t5_geom", 32'(err_geom), 32'd1);
        chk("t5_fc", 32'(frame_count), 32'd3);
        drain("t5_drain");

        // Random pixel data with a stuttering slave
        ack_rand = 1'b1;
        frame(TOT, TOT, 1'b1, -1);
        chk("rnd_fc", 32'(frame_count), 32'd4);
        drain("rnd_drain");
        ack_rand = 1'b0;

        // Enable drops mid-frame: frame completes, then idle
        frame(TOT, TOT, 1'b0, 10);
        chk("t6_fc_prev", 32'(frame_count), 32'd5);
        drain("t6_drain");
        frame(TOT, 0, 1'b0, -1);
        chk("t6_fc", 32'(frame_count), 32'd6);
        vs_pulse();
        chk("t6_fc_idle", 32'(frame_count), 32'd6);
        drain("t6_idle_drain");
        chk("total_writes", 32'(writes), 32'd228);
        chk("end_cyc", 32'(wshb_cyc), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
